// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
//   Handles load-use stalls, taken-branch flushes and data-memory wait.
//   Also keeps saturating performance counters.
// Ports:
//   clk, reset (sync, active-low)
//   MemRead_IDEX, Rd_IDEX      ID-EX load flag and destination register
//   Rs1_IFID, Rs2_IFID         IF-ID source registers
//   branch_taken, mem_busy     EX redirect request, data-memory not ready
//   clr_cnt                    synchronous clear of all counters
//   pc_write, ifid_write       PC / IF-ID update enables
//   flush_IFID, flush_IDEX     zero IF-ID / ID-EX at the next edge
//   freeze                     hold ID-EX, EX-MEM and MEM-WB
//   stall_cnt, flush_cnt, freeze_cnt  saturating event counters
module hazard_ctrl #(
    parameter int BRANCH_BUBBLES = 2,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_IDEX,
    input  logic [4:0]       Rd_IDEX,
    input  logic [4:0]       Rs1_IFID,
    input  logic [4:0]       Rs2_IFID,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             clr_cnt,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);
    localparam int BW = BRANCH_BUBBLES > 1 ? $clog2(BRANCH_BUBBLES) : 1;
    localparam logic [BW-1:0] BUB_INIT = BW'(BRANCH_BUBBLES - 1);

    typedef enum logic [1:0] {RUN, FLUSH, FREEZE} state_t;

    state_t state, state_n, eff;
    logic [BW-1:0] bub_left, bub_n;
    logic lu, inc_stall, inc_flush, inc_freeze;

    assign lu = MemRead_IDEX && Rd_IDEX != 5'd0 && (Rd_IDEX == Rs1_IFID || Rd_IDEX == Rs2_IFID);

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && !(&c)) ? c + CNT_W'(1) : c;
    endfunction

    always_comb begin
        // Leaving FREEZE behaves in the same cycle as the state it resumes into.
        eff = (state == FREEZE && !mem_busy) ? ((bub_left != '0) ? FLUSH : RUN) : state;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        flush_IFID = 1'b0;
        flush_IDEX = 1'b0;
        freeze     = 1'b0;
        state_n    = eff;
        bub_n      = bub_left;
        inc_stall  = 1'b0;
        inc_flush  = 1'b0;
        inc_freeze = 1'b0;
        if (!reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
            state_n    = RUN;
            bub_n      = '0;
        end else if (mem_busy) begin
            // EX is frozen, so a pending branch stays asserted and is handled on release.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            freeze     = 1'b1;
            state_n    = FREEZE;
            inc_freeze = 1'b1;
        end else if (branch_taken) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
            bub_n      = BUB_INIT;
            state_n    = (BUB_INIT != '0) ? FLUSH : RUN;
            inc_flush  = 1'b1;
        end else if (eff == FLUSH) begin
            flush_IFID = 1'b1;
            bub_n      = bub_left - BW'(1);
            state_n    = (bub_left == BW'(1)) ? RUN : FLUSH;
        end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            flush_IDEX = 1'b1;
            inc_stall  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= RUN;
            bub_left   <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            state    <= state_n;
            bub_left <= bub_n;
            if (clr_cnt) begin
                stall_cnt  <= '0;
                flush_cnt  <= '0;
                freeze_cnt <= '0;
            end else begin
                stall_cnt  <= bump(stall_cnt, inc_stall);
                flush_cnt  <= bump(flush_cnt, inc_flush);
                freeze_cnt <= bump(freeze_cnt, inc_freeze);
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (BRANCH_BUBBLES=2, CNT_W=4).
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset, MemRead_IDEX, branch_taken, mem_busy, clr_cnt;
    logic [4:0] Rd_IDEX, Rs1_IFID, Rs2_IFID;
    logic pc_write, ifid_write, flush_IFID, flush_IDEX, freeze;
    logic [3:0] stall_cnt, flush_cnt, freeze_cnt;
    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];
    string tag_q[$];

    // expected output vectors: {pc_write, ifid_write, flush_IFID, flush_IDEX, freeze}
    localparam logic [4:0] O_RST = 5'b00110;
    localparam logic [4:0] O_RUN = 5'b11000;
    localparam logic [4:0] O_STL = 5'b00010;
    localparam logic [4:0] O_BR  = 5'b11110;
    localparam logic [4:0] O_FL  = 5'b11100;
    localparam logic [4:0] O_FRZ = 5'b00001;

    hazard_ctrl #(.BRANCH_BUBBLES(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .MemRead_IDEX(MemRead_IDEX), .Rd_IDEX(Rd_IDEX),
        .Rs1_IFID(Rs1_IFID), .Rs2_IFID(Rs2_IFID), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .clr_cnt(clr_cnt), .pc_write(pc_write), .ifid_write(ifid_write),
        .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .freeze(freeze),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue the expected outputs, compare them mid-cycle.
    task automatic step(input logic rst_n, input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic bt, input logic mb, input logic clr,
                        input logic [4:0] exp, input string tag);
        logic [4:0] got, e;
        string t;
        reset = rst_n; MemRead_IDEX = mr; Rd_IDEX = rd; Rs1_IFID = rs1; Rs2_IFID = rs2;
        branch_taken = bt; mem_busy = mb; clr_cnt = clr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        got = {pc_write, ifid_write, flush_IFID, flush_IDEX, freeze};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s: outputs got %b expected %b", t, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] exp, input string tag);
        step(1, 0, 0, 0, 0, 0, 0, 0, exp, tag);
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [3:0] s, input logic [3:0] f, input logic [3:0] z);
        chk({tag, "_stall"}, stall_cnt, s);
        chk({tag, "_flush"}, flush_cnt, f);
        chk({tag, "_freeze"}, freeze_cnt, z);
    endtask

    initial begin
        reset = 0; MemRead_IDEX = 0; Rd_IDEX = 0; Rs1_IFID = 0; Rs2_IFID = 0;
        branch_taken = 0; mem_busy = 0; clr_cnt = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, O_RST, "reset");
        chk_cnt("after_reset", 0, 0, 0);
        idle(O_RUN, "run_normal");
        // load-use on rs2, then on rs1
        step(1, 1, 5, 1, 5, 0, 0, 0, O_STL, "lu_rs2");
        chk("lu_rs2_cnt", stall_cnt, 1);
        idle(O_RUN, "after_lu");
        step(1, 1, 7, 7, 3, 0, 0, 0, O_STL, "lu_rs1");
        chk("lu_rs1_cnt", stall_cnt, 2);
        // rd=x0 and non-load never stall
        step(1, 1, 0, 0, 0, 0, 0, 0, O_RUN, "lu_rd0");
        step(1, 0, 5, 5, 5, 0, 0, 0, O_RUN, "no_load");
        chk("no_stall_cnt", stall_cnt, 2);
        // taken branch: two flush cycles, first one also bubbles ID-EX
        step(1, 0, 0, 0, 0, 1, 0, 0, O_BR, "branch");
        idle(O_FL, "branch_flush2");
        idle(O_RUN, "branch_done");
        chk("branch_cnt", flush_cnt, 1);
        // branch beats load-use; load-use ignored during FLUSH
        step(1, 1, 9, 9, 0, 1, 0, 0, O_BR, "br_vs_lu");
        step(1, 1, 9, 9, 0, 0, 0, 0, O_FL, "lu_in_flush");
        idle(O_RUN, "br_vs_lu_done");
        chk_cnt("br_vs_lu", 2, 2, 0);
        // branch during FLUSH restarts the bubbles
        step(1, 0, 0, 0, 0, 1, 0, 0, O_BR, "br1");
        step(1, 0, 0, 0, 0, 1, 0, 0, O_BR, "br_in_flush");
        idle(O_FL, "restart_flush");
        idle(O_RUN, "restart_done");
        chk("restart_cnt", flush_cnt, 4);
        // mem_busy for 4 cycles while FLUSH has one bubble left
        step(1, 0, 0, 0, 0, 1, 0, 0, O_BR, "br_busy");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 1, 0, O_FRZ, "busy_in_flush");
        idle(O_FL, "resume_flush");
        idle(O_RUN, "resume_run");
        chk_cnt("busy_flush", 2, 5, 4);
        // branch held high while frozen is deferred until release
        step(1, 0, 0, 0, 0, 1, 1, 0, O_FRZ, "busy_br");
        step(1, 0, 0, 0, 0, 1, 1, 0, O_FRZ, "busy_br2");
        chk("deferred_cnt", flush_cnt, 5);
        step(1, 0, 0, 0, 0, 1, 0, 0, O_BR, "release_br");
        idle(O_FL, "release_flush");
        idle(O_RUN, "release_run");
        chk_cnt("deferred", 2, 6, 6);
        // freeze from RUN releases straight into a load-use stall
        step(1, 0, 0, 0, 0, 0, 1, 0, O_FRZ, "busy_run");
        step(1, 1, 3, 3, 0, 0, 0, 0, O_STL, "release_lu");
        chk_cnt("release_lu", 3, 6, 7);
        // reset mid-FLUSH abandons the remaining bubble
        step(1, 0, 0, 0, 0, 1, 0, 0, O_BR, "br_before_rst");
        step(0, 0, 0, 0, 0, 0, 0, 0, O_RST, "rst_in_flush");
        chk_cnt("rst_mid", 0, 0, 0);
        idle(O_RUN, "after_rst_mid");
        // saturation at 15 and clear overriding an increment
        for (int i = 0; i < 20; i++) step(1, 1, 4, 0, 4, 0, 0, 0, O_STL, "sat_lu");
        chk("sat_cnt", stall_cnt, 15);
        step(1, 0, 0, 0, 0, 0, 1, 0, O_FRZ, "busy_pre_clr");
        step(1, 1, 4, 4, 0, 0, 0, 1, O_STL, "clr_with_lu");
        chk_cnt("clr", 0, 0, 0);
        step(1, 1, 4, 4, 0, 0, 0, 0, O_STL, "lu_after_clr");
        chk("after_clr_cnt", stall_cnt, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
